register_writeback: RTL
=======================

# register_writeback

Writeback arbiter and load scoreboard for the RV32I core. It merges single-cycle ALU results and multi-cycle load returns onto the register file's single write port (A3/WD3/WE3). It tracks registers with outstanding loads and raises a decode stall on read-after-write hazards. It sits between the execute/memory stages and the register file write port.

## Interface
- XLEN, 32, data width
- LD_DEPTH, 4, load-return FIFO entries (power of 2, ≥2)

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result present this cycle; no backpressure
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- ld_valid  in  1  load return valid
- ld_ready  out  1  load return accepted when ld_valid & ld_ready
- ld_rd  in  5  load destination register
- ld_data  in  XLEN  load data
- issue_valid  in  1  load issued this cycle; marks issue_rd pending
- issue_rd  in  5  destination of issued load
- rs1, rs2  in  5  decode-stage source registers
- stall  out  1  decode must hold
- WE3  out  1  register file write enable, registered
- A3  out  5  register file write address, registered
- WD3  out  XLEN  register file write data, registered

## Operation
- Load FIFO:
  - Push on ld_valid & ld_ready.
  - ld_ready = !rst & (count < LD_DEPTH); purely from count, with no same-cycle pop bypass when full.
- Write arbitration, evaluated every cycle (ALU strictly first):
  - If alu_valid: output registers take {1, alu_rd, alu_data}. The FIFO does not pop.
  - Else if FIFO non-empty: pop the head; output registers take {1, head.rd, head.data}.
  - Else: WE3 <= 0; A3/WD3 hold their previous values.
- Writes to x0:
  - A selected source with rd == 0 produces WE3 <= 0.
  - The source is still consumed (the FIFO still pops).
- Scoreboard: pending[31:0], with bit 0 hardwired to 0.
  - Set: issue_valid & issue_rd != 0 sets pending[issue_rd].
  - Clear: a FIFO-sourced write with head.rd == r clears pending[r] in the same cycle the pop occurs.
  - Set and clear of the same bit in one cycle: set wins.
  - ALU writes never touch pending.
- stall = (rs1 != 0 & pending[rs1]) | (rs2 != 0 & pending[rs2]) | (issue_valid & issue_rd != 0 & pending[issue_rd]).
  - Combinational from registered state.
  - Upstream must not issue while stalled.
- Sustained alu_valid starves the FIFO. When the FIFO is full, ld_ready stays low until an ALU-idle cycle. This is accepted behaviour and not an error.

## Timing
- Reset, held for one or more cycles:
  - WE3=0, A3=0, WD3=0.
  - FIFO empty (count=0), pending=0, stall=0.
  - ld_ready=0 while rst is high, 1 in the first cycle after rst falls.
- ALU latency: alu_valid at cycle N gives WE3/A3/WD3 valid in cycle N+1.
- Load latency: a handshake at edge N, with no ALU traffic in cycle N+1, gives the write visible in cycle N+2.
  - pending clears at the same edge, so stall drops in cycle N+2.
- Throughput: one write per cycle. A full FIFO drains in LD_DEPTH ALU-idle cycles.
- Simultaneous push and pop in one cycle: count is unchanged and pointers wrap modulo LD_DEPTH.
- Reset mid-operation:
  - FIFO contents are discarded and pending is cleared.
  - Writes in flight are dropped. WE3 is 0 in the cycle after the reset edge.

## Structure
- Package rv32i_pkg holds XLEN, REG_ADDR_W=5, NUM_REGS=32, and the load-return entry struct {rd, data}.
- Sub-module wb_fifo:
  - Synchronous FIFO with parameterised depth and entry width.
  - Ports: push, pop, full, empty, count, din, dout.
  - dout is the head entry, readable combinationally.
- Top level contains the arbiter, output registers and scoreboard.

## Test plan
- Reset then idle:
  - WE3=0, A3=0, WD3=0, stall=0 throughout.
  - ld_ready=1 one cycle after rst falls.
- ALU write:
  - alu_valid, alu_rd=5, alu_data=0x0000_00AA at cycle N → WE3=1, A3=5, WD3=0xAA in cycle N+1.
  - Same stimulus with alu_rd=0 → WE3=0.
- Load hazard:
  - issue_valid, issue_rd=9 → with rs1=9, stall=1 from the next cycle.
  - ld_rd=9, ld_data=0x1234 handshake at N → WE3=1, A3=9, WD3=0x1234 at N+2, and stall=0 at N+2.
- Conflict:
  - alu_valid (rd=3) held 6 cycles while 4 loads arrive → ld_ready drops after the 4th push.
  - After ALU idles, loads are written in arrival order on 4 consecutive cycles.
- Set/clear collision:
  - FIFO pop for rd=7 in the same cycle as issue_valid with issue_rd=7 → pending[7] remains 1.
- Reset mid-drain:
  - rst asserted with 3 FIFO entries and pending={4,6} → next cycle WE3=0, pending=0, FIFO empty.
  - No stale write appears after rst falls.

Source files
------------

// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_pkg
// Description : Shared widths, load-return entry type and writeback source tag
// Revision    : 1.0
// ============================================================================
package rv32i_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } ld_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LD   = 2'd2
    } wb_src_t;

    function automatic logic reg_is_zero(input logic [REG_ADDR_W-1:0] r);
        return r == '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/register_writeback_if.sv
`default_nettype none
// ============================================================================
// Module      : register_writeback_if
// Description : Execute/memory-side writeback bus and register-file write port
// Revision    : 1.0
// ============================================================================
interface register_writeback_if #(
    parameter int XLEN = 32
) ();

    logic                              alu_valid;
    logic [rv32i_pkg::REG_ADDR_W-1:0]  alu_rd;
    logic [XLEN-1:0]                   alu_data;

    logic                              ld_valid;
    logic                              ld_ready;
    logic [rv32i_pkg::REG_ADDR_W-1:0]  ld_rd;
    logic [XLEN-1:0]                   ld_data;

    logic                              issue_valid;
    logic [rv32i_pkg::REG_ADDR_W-1:0]  issue_rd;
    logic [rv32i_pkg::REG_ADDR_W-1:0]  rs1;
    logic [rv32i_pkg::REG_ADDR_W-1:0]  rs2;
    logic                              stall;

    logic                              WE3;
    logic [rv32i_pkg::REG_ADDR_W-1:0]  A3;
    logic [XLEN-1:0]                   WD3;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        output issue_valid, issue_rd, rs1, rs2,
        input  ld_ready, stall, WE3, A3, WD3
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        input  issue_valid, issue_rd, rs1, rs2,
        output ld_ready, stall, WE3, A3, WD3
    );

endinterface
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Synchronous FIFO with combinational head read (power-of-2 depth)
// Revision    : 1.0
// ============================================================================
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic             pop,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      count,
    input  wire logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0]      dout
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage carries no reset; validity is tracked entirely by r_count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/register_writeback.sv
`default_nettype none
// ============================================================================
// Module      : register_writeback
// Description : ALU/load writeback arbiter with load-pending scoreboard and stall
// Revision    : 1.0
// ============================================================================
module register_writeback #(
    parameter int XLEN     = rv32i_pkg::XLEN,
    parameter int LD_DEPTH = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    register_writeback_if.slave  wb
);

    import rv32i_pkg::*;

    localparam int CNT_W = $clog2(LD_DEPTH) + 1;

    ld_entry_t             w_push_entry;
    ld_entry_t             w_head;
    logic                  w_full;
    logic                  w_empty;
    logic [CNT_W-1:0]      w_count;
    logic                  w_push;
    logic                  w_pop;
    wb_src_t               w_src;

    logic                  r_we3;
    logic [REG_ADDR_W-1:0] r_a3;
    logic [XLEN-1:0]       r_wd3;

    logic [NUM_REGS-1:0]   r_pending;
    logic [NUM_REGS-1:0]   w_pending_set;
    logic [NUM_REGS-1:0]   w_pending_clr;
    logic [NUM_REGS-1:0]   w_pending_nxt;

    // Ready depends only on occupancy; a full FIFO will not accept even if it pops.
    assign wb.ld_ready = !rst && (w_count < CNT_W'(LD_DEPTH));
    assign w_push      = wb.ld_valid && !rst && !w_full;

    always_comb begin
        w_push_entry      = '0;
        w_push_entry.rd   = wb.ld_rd;
        w_push_entry.data = wb.ld_data;
    end

    wb_fifo #(
        .DEPTH (LD_DEPTH),
        .WIDTH ($bits(ld_entry_t)),
        .CNT_W (CNT_W)
    ) u_ld_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count),
        .din   (w_push_entry),
        .dout  (w_head)
    );

    // ALU results have no backpressure, so they always win the write port.
    always_comb begin
        w_src = SRC_NONE;
        if (wb.alu_valid) begin
            w_src = SRC_ALU;
        end else if (!w_empty) begin
            w_src = SRC_LD;
        end
    end

    assign w_pop = (w_src == SRC_LD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we3 <= 1'b0;
            r_a3  <= '0;
            r_wd3 <= '0;
        end else begin
            case (w_src)
                SRC_ALU: begin
                    r_we3 <= !reg_is_zero(wb.alu_rd);
                    r_a3  <= wb.alu_rd;
                    r_wd3 <= wb.alu_data;
                end
                SRC_LD: begin
                    r_we3 <= !reg_is_zero(w_head.rd);
                    r_a3  <= w_head.rd;
                    r_wd3 <= w_head.data;
                end
                default: begin
                    r_we3 <= 1'b0;
                end
            endcase
        end
    end

    assign wb.WE3 = r_we3;
    assign wb.A3  = r_a3;
    assign wb.WD3 = r_wd3;

    // A new issue to a register overrides a same-cycle load completion to it.
    always_comb begin
        w_pending_set = '0;
        w_pending_clr = '0;
        if (wb.issue_valid && !reg_is_zero(wb.issue_rd)) begin
            w_pending_set[wb.issue_rd] = 1'b1;
        end
        if (w_pop) begin
            w_pending_clr[w_head.rd] = 1'b1;
        end
        w_pending_nxt    = (r_pending & ~w_pending_clr) | w_pending_set;
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign wb.stall = (!reg_is_zero(wb.rs1) && r_pending[wb.rs1])
                    || (!reg_is_zero(wb.rs2) && r_pending[wb.rs2])
                    || (wb.issue_valid && !reg_is_zero(wb.issue_rd) && r_pending[wb.issue_rd]);

endmodule
`default_nettype wire
